scope_video_ctrl_mc: RTL

Parametrised, multi-channel successor to the single-trace oscilloscope video controller. It generates programmable raster timing and captures one column of samples per channel into a double-buffered sample store. Each frame it renders a graticule plus up to N_CH coloured traces. Its outputs drive the existing TMDS/HDMI interface unchanged: VDE, hsync, vsync and 24-bit pixel.

---
 rtl/scope_video_ctrl_mc_if.sv | 58 +++++
 rtl/scope_video_ctrl_mc.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_video_ctrl_mc_if.sv
// Sample-capture inputs and video outputs of scope_video_ctrl_mc.
// trig_level_i exists only when TRIGGER_EN is defined.
interface scope_video_ctrl_mc_if #(
  parameter int N_CH     = 2,
  parameter int SAMPLE_W = 12
);
  logic                       en_i;
  logic                       sample_valid_i;
  logic [N_CH*SAMPLE_W-1:0]   samples_i;
  logic [N_CH-1:0]            ch_en_i;
  logic [N_CH*24-1:0]         trace_rgb_i;
  logic [23:0]                bg_pixel_i;
`ifdef TRIGGER_EN
  logic [SAMPLE_W-1:0]        trig_level_i;
`endif
  logic                       VDEn_o;
  logic                       hSync_o;
  logic                       vSync_o;
  logic [23:0]                pixel_o;
  logic                       frame_start_o;
  logic                       buf_swap_o;

  modport master (
    output en_i,
    output sample_valid_i,
    output samples_i,
    output ch_en_i,
    output trace_rgb_i,
    output bg_pixel_i,
`ifdef TRIGGER_EN
    output trig_level_i,
`endif
    input  VDEn_o,
    input  hSync_o,
    input  vSync_o,
    input  pixel_o,
    input  frame_start_o,
    input  buf_swap_o
  );

  modport slave (
    input  en_i,
    input  sample_valid_i,
    input  samples_i,
    input  ch_en_i,
    input  trace_rgb_i,
    input  bg_pixel_i,
`ifdef TRIGGER_EN
    input  trig_level_i,
`endif
    output VDEn_o,
    output hSync_o,
    output vSync_o,
    output pixel_o,
    output frame_start_o,
    output buf_swap_o
  );
endinterface

// File: rtl/scope_video_ctrl_mc.sv
// Multi-channel scope video: raster timing, double-buffered capture, trace render.
// Define TRIGGER_EN to arm capture on a channel-0 rising crossing of trig_level_i.
module scope_video_ctrl_mc #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int N_CH     = 2,
  parameter int SAMPLE_W = 12,
  parameter int GRID_DIV = 64
) (
  input logic                  pixclk_i,
  input logic                  rst_i,
  scope_video_ctrl_mc_if.slave bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CW = $clog2(H_ACTIVE);
  localparam int DW = N_CH * SAMPLE_W;
  localparam logic [31:0] GMASK = 32'(GRID_DIV - 1);
  localparam logic [23:0] GRID_RGB = 24'h404040;

  typedef enum logic [1:0] {
    IDLE, ARMED, CAPTURE, DONE
  } cap_state_e;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic frame_seen_q, frame_seen_d;
  logic h_wrap, frame_top;

  always_comb begin
    h_wrap = (hcnt_q == HW'(H_TOTAL - 1));
    frame_top = (hcnt_q == '0) && (vcnt_q == '0);
    hcnt_d = h_wrap ? '0 : hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    frame_seen_d = frame_seen_q;
    if (h_wrap) begin
      if (vcnt_q == VW'(V_TOTAL - 1)) begin
        vcnt_d = '0;
        frame_seen_d = 1'b1;
      end else begin
        vcnt_d = vcnt_q + VW'(1);
      end
    end
  end

  cap_state_e state_q, state_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic front_q, front_d;
  logic fv_q, fv_d;
  logic wr_en, swap, arm_chk, take;
  logic [CW-1:0] wr_addr;
`ifdef TRIGGER_EN
  logic [SAMPLE_W-1:0] prev_q, prev_d, prev_eff, s0;
  assign s0 = bus.samples_i[SAMPLE_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    wr_col_d = wr_col_q;
    front_d = front_q;
    fv_d = fv_q;
    wr_en = 1'b0;
    wr_addr = wr_col_q;
    swap = 1'b0;
    arm_chk = 1'b0;
    take = 1'b0;
`ifdef TRIGGER_EN
    prev_d = prev_q;
    prev_eff = prev_q;
`endif
    if (!bus.en_i) begin
      state_d = IDLE;
      wr_col_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARMED;
          wr_col_d = '0;
`ifdef TRIGGER_EN
          prev_d = '0;
`endif
        end
        ARMED: arm_chk = 1'b1;
        CAPTURE: begin
          if (bus.sample_valid_i) begin
            wr_en = 1'b1;
            if (wr_col_q == CW'(H_ACTIVE - 1)) state_d = DONE;
            else wr_col_d = wr_col_q + CW'(1);
          end
        end
        DONE: begin
          if (frame_top) begin
            swap = 1'b1;
            front_d = ~front_q;
            fv_d = 1'b1;
            state_d = ARMED;
            wr_col_d = '0;
            arm_chk = 1'b1;
`ifdef TRIGGER_EN
            prev_d = '0;
            prev_eff = '0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
      // ARMED behaviour also applies in the swap cycle itself
      if (arm_chk && bus.sample_valid_i) begin
`ifdef TRIGGER_EN
        prev_d = s0;
        take = (prev_eff < bus.trig_level_i) &&
               (s0 >= bus.trig_level_i);
`else
        take = 1'b1;
`endif
      end
      if (take) begin
        wr_en = 1'b1;
        wr_addr = '0;
        wr_col_d = CW'(1);
        state_d = CAPTURE;
      end
    end
  end

  always_ff @(posedge pixclk_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      frame_seen_q <= 1'b0;
      state_q <= IDLE;
      wr_col_q <= '0;
      front_q <= 1'b0;
      fv_q <= 1'b0;
`ifdef TRIGGER_EN
      prev_q <= '0;
`endif
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      frame_seen_q <= frame_seen_d;
      state_q <= state_d;
      wr_col_q <= wr_col_d;
      front_q <= front_d;
      fv_q <= fv_d;
`ifdef TRIGGER_EN
      prev_q <= prev_d;
`endif
    end
  end

  logic [DW-1:0] store [2][H_ACTIVE];
  logic [DW-1:0] s1_smp_q;
  logic [CW-1:0] rd_col;
  logic in_h;

  assign in_h = (hcnt_q < HW'(H_ACTIVE));
  assign rd_col = in_h ? CW'(hcnt_q) : '0;

  // Display reads with the post-swap bank so a new image starts on pixel 0
  always_ff @(posedge pixclk_i) begin
    if (wr_en) store[~front_d][wr_addr] <= bus.samples_i;
    s1_smp_q <= store[front_d][rd_col];
  end

  logic s1_act_d, s1_hs_d, s1_vs_d, s1_fs_d, s1_grid_d, s1_show_d;
  logic s1_act_q, s1_hs_q, s1_vs_q, s1_fs_q, s1_grid_q, s1_show_q;
  logic s1_swap_q;
  logic [N_CH-1:0] s1_chen_q;
  logic [VW-1:0] s1_y_q;
  logic [N_CH*24-1:0] s1_rgb_q;
  logic [23:0] s1_bg_q;

  always_comb begin
    s1_act_d = in_h && (vcnt_q < VW'(V_ACTIVE));
    s1_hs_d = (hcnt_q >= HW'(H_ACTIVE + H_FP)) &&
              (hcnt_q < HW'(H_ACTIVE + H_FP + H_SYNC));
    s1_vs_d = (vcnt_q >= VW'(V_ACTIVE + V_FP)) &&
              (vcnt_q < VW'(V_ACTIVE + V_FP + V_SYNC));
    s1_fs_d = frame_top && frame_seen_q;
    s1_grid_d = ((32'(hcnt_q) & GMASK) == 32'd0) ||
                ((32'(vcnt_q) & GMASK) == 32'd0) ||
                (hcnt_q == HW'(H_ACTIVE - 1)) ||
                (vcnt_q == VW'(V_ACTIVE - 1));
    s1_show_d = bus.en_i && fv_d;
  end

  always_ff @(posedge pixclk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_act_q <= 1'b0;
      s1_hs_q <= 1'b0;
      s1_vs_q <= 1'b0;
      s1_fs_q <= 1'b0;
      s1_swap_q <= 1'b0;
      s1_grid_q <= 1'b0;
      s1_show_q <= 1'b0;
      s1_chen_q <= '0;
      s1_y_q <= '0;
      s1_rgb_q <= '0;
      s1_bg_q <= '0;
    end else begin
      s1_act_q <= s1_act_d;
      s1_hs_q <= s1_hs_d;
      s1_vs_q <= s1_vs_d;
      s1_fs_q <= s1_fs_d;
      s1_swap_q <= swap;
      s1_grid_q <= s1_grid_d;
      s1_show_q <= s1_show_d;
      s1_chen_q <= bus.ch_en_i;
      s1_y_q <= vcnt_q;
      s1_rgb_q <= bus.trace_rgb_i;
      s1_bg_q <= bus.bg_pixel_i;
    end
  end

  logic [23:0] pix_d, pix_q;
  logic [63:0] prod, row;
  logic vde_q, hsync_q, vsync_q, fs_q, swap_q;

  // Descending scan: the lowest lit channel is written last and wins
  always_comb begin
    pix_d = '0;
    prod = '0;
    row = '0;
    if (s1_act_q) begin
      pix_d = s1_grid_q ? GRID_RGB : s1_bg_q;
      for (int k = N_CH - 1; k >= 0; k--) begin
        prod = 64'(s1_smp_q[k*SAMPLE_W +: SAMPLE_W]) * 64'(V_ACTIVE);
        row = 64'(V_ACTIVE - 1) - (prod >> SAMPLE_W);
        if (s1_show_q && s1_chen_q[k] && (row == 64'(s1_y_q)))
          pix_d = s1_rgb_q[k*24 +: 24];
      end
    end
  end

  always_ff @(posedge pixclk_i or posedge rst_i) begin
    if (rst_i) begin
      vde_q <= 1'b0;
      hsync_q <= (SYNC_POL == 0);
      vsync_q <= (SYNC_POL == 0);
      pix_q <= '0;
      fs_q <= 1'b0;
      swap_q <= 1'b0;
    end else begin
      vde_q <= s1_act_q;
      hsync_q <= (SYNC_POL != 0) ? s1_hs_q : !s1_hs_q;
      vsync_q <= (SYNC_POL != 0) ? s1_vs_q : !s1_vs_q;
      pix_q <= pix_d;
      fs_q <= s1_fs_q;
      swap_q <= s1_swap_q;
    end
  end

  assign bus.VDEn_o = vde_q;
  assign bus.hSync_o = hsync_q;
  assign bus.vSync_o = vsync_q;
  assign bus.pixel_o = pix_q;
  assign bus.frame_start_o = fs_q;
  assign bus.buf_swap_o = swap_q;
endmodule
